// File: rtl/cpu_pkg.sv
// Shared encodings for the 4-bit Von Neumann CPU: control-state codes seen by
// sel_dato, opcodes and ALU function selects.
package cpu_pkg;

    typedef enum logic [4:0] {
        CS_IDLE       = 5'b00000,
        CS_FETCH_OP   = 5'b00001,
        CS_FETCH_ADDR = 5'b00010,
        CS_DECODE     = 5'b00011,
        CS_LOAD_CAP   = 5'b10110,
        CS_ALU_WB     = 5'b10101,
        CS_STORE      = 5'b11000,
        CS_JUMP       = 5'b11001,
        CS_HALT       = 5'b11111
    } cs_e;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_JMP   = 4'h7;
    localparam logic [3:0] OP_JZ    = 4'h8;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    // ALU opcodes are contiguous from ADD, so the select is just the offset.
    function automatic logic [1:0] alu_sel(input logic [3:0] op);
        logic [3:0] off;
        off = op - OP_ADD;
        return off[1:0];
    endfunction

endpackage

// File: rtl/contador_pc.sv
// Program counter: wraps modulo 2^ADDR_W, load has priority over increment.
module contador_pc #(
    parameter int ADDR_W   = 4,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_inc,
    input  logic [ADDR_W-1:0] i_din,
    output logic [ADDR_W-1:0] o_pc
);

    logic [ADDR_W-1:0] r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_pc <= ADDR_W'(RESET_PC);
        else if (i_load)
            r_pc <= i_din;
        else if (i_inc)
            r_pc <= r_pc + ADDR_W'(1);
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/unidad_control.sv
// Control sequencer: fetches opcode/operand nibbles, decodes, and steps
// through one-cycle execute states whose codes drive sel_dato directly.
module unidad_control
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 4,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              acc_zero,
    output logic [4:0]        cs,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [1:0]        alu_op,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    cs_e               r_state;
    cs_e               w_next;
    cs_e               w_after;
    logic [DATA_W-1:0] r_ir;
    logic [ADDR_W-1:0] r_ar;
    logic [1:0]        r_alu_op;
    logic              w_pc_inc;
    logic              w_pc_load;
    logic [3:0]        w_op;

    assign w_op = r_ir[3:0];

    contador_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_pc_load),
        .i_inc  (w_pc_inc),
        .i_din  (r_ar),
        .o_pc   (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= CS_IDLE;
        else
            r_state <= w_next;
    end

    // run is only consulted between instructions, so dropping it never aborts one.
    always_comb begin
        w_after = run ? CS_FETCH_OP : CS_IDLE;
        w_next  = r_state;
        case (r_state)
            CS_IDLE:       w_next = run ? CS_FETCH_OP : CS_IDLE;
            CS_FETCH_OP:   w_next = CS_FETCH_ADDR;
            CS_FETCH_ADDR: w_next = CS_DECODE;
            CS_DECODE: begin
                case (w_op)
                    OP_LOAD:                        w_next = CS_LOAD_CAP;
                    OP_ADD, OP_SUB, OP_AND, OP_OR:  w_next = CS_ALU_WB;
                    OP_STORE:                       w_next = CS_STORE;
                    OP_JMP:                         w_next = CS_JUMP;
                    OP_JZ:                          w_next = acc_zero ? CS_JUMP : w_after;
                    OP_HALT:                        w_next = CS_HALT;
                    default:                        w_next = w_after;
                endcase
            end
            CS_LOAD_CAP, CS_ALU_WB, CS_STORE, CS_JUMP: w_next = w_after;
            CS_HALT:       w_next = CS_HALT;
            default:       w_next = CS_IDLE;
        endcase
    end

    always_comb begin
        w_pc_inc  = (r_state == CS_FETCH_OP) || (r_state == CS_FETCH_ADDR);
        w_pc_load = (r_state == CS_JUMP);
        mem_addr  = w_pc_inc ? pc : r_ar;
        mem_we    = (r_state == CS_STORE);
        halted    = (r_state == CS_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir     <= '0;
            r_ar     <= '0;
            r_alu_op <= ALU_ADD;
        end else begin
            if (r_state == CS_FETCH_OP)
                r_ir <= mem_data;
            if (r_state == CS_FETCH_ADDR)
                r_ar <= ADDR_W'(mem_data);
            if (r_state == CS_DECODE && w_next == CS_ALU_WB)
                r_alu_op <= alu_sel(w_op);
        end
    end

    assign cs     = r_state;
    assign alu_op = r_alu_op;

endmodule

// File: tb/tb_unidad_control.sv
// Scoreboard bench: per-instruction cycle expectations are queued from the
// instruction timing rules, then popped and compared one clock at a time.
module tb_unidad_control;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [3:0] mem_data;
    logic       acc_zero;
    logic [4:0] cs;
    logic [3:0] mem_addr;
    logic       mem_we;
    logic [1:0] alu_op;
    logic [3:0] pc;
    logic       halted;

    logic [3:0] mem [16];
    logic [3:0] img [16];
    logic       ld = 1'b0;
    logic [3:0] acc;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [4:0] cs;
        logic [3:0] addr;
        logic [3:0] pc;
        logic       we;
        logic [1:0] alu;
        logic       chk_alu;
        logic       drop;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] epc;

    always #5 clk = ~clk;

    unidad_control #(.ADDR_W(4), .DATA_W(4), .RESET_PC(0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .mem_data (mem_data),
        .acc_zero (acc_zero),
        .cs       (cs),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .alu_op   (alu_op),
        .pc       (pc),
        .halted   (halted)
    );

    // memory and sel_dato/ALU environment
    assign mem_data = mem[mem_addr];
    assign acc_zero = (acc == 4'h0);

    always @(posedge clk) begin
        if (ld)
            mem <= img;
        else if (mem_we)
            mem[mem_addr] <= acc;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= 4'h0;
        else if (cs == CS_LOAD_CAP)
            acc <= mem_data;
        else if (cs == CS_ALU_WB)
            case (alu_op)
                2'b00:   acc <= acc + mem_data;
                2'b01:   acc <= acc - mem_data;
                2'b10:   acc <= acc & mem_data;
                default: acc <= acc | mem_data;
            endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [4:0] c, input logic [3:0] a, input logic [3:0] p,
                        input logic we = 1'b0, input logic [1:0] al = 2'b00,
                        input logic ca = 1'b0, input logic dr = 1'b0);
        exp_t e;
        e.cs = c; e.addr = a; e.pc = p; e.we = we; e.alu = al; e.chk_alu = ca; e.drop = dr;
        sb.push_back(e);
    endtask

    task automatic ex(input logic [3:0] op, input logic [3:0] opd, input logic az,
                      input logic drop = 1'b0);
        logic [3:0] p1, p2;
        p1 = epc + 4'd1;
        p2 = epc + 4'd2;
        push(CS_FETCH_OP, epc, epc);
        push(CS_FETCH_ADDR, p1, p1, 1'b0, 2'b00, 1'b0, drop);
        push(CS_DECODE, opd, p2);
        case (op)
            4'h1: push(CS_LOAD_CAP, opd, p2);
            4'h2: push(CS_STORE, opd, p2, 1'b1);
            4'h3: push(CS_ALU_WB, opd, p2, 1'b0, 2'b00, 1'b1);
            4'h4: push(CS_ALU_WB, opd, p2, 1'b0, 2'b01, 1'b1);
            4'h5: push(CS_ALU_WB, opd, p2, 1'b0, 2'b10, 1'b1);
            4'h6: push(CS_ALU_WB, opd, p2, 1'b0, 2'b11, 1'b1);
            4'h7: begin push(CS_JUMP, opd, p2); p2 = opd; end
            4'h8: if (az) begin push(CS_JUMP, opd, p2); p2 = opd; end
            4'hF: push(CS_HALT, opd, p2);
            default: ;
        endcase
        epc = p2;
    endtask

    task automatic drain(input string name);
        exp_t e;
        int   k = 0;
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            chk($sformatf("%s.cs[%0d]", name, k), cs, e.cs);
            chk($sformatf("%s.addr[%0d]", name, k), mem_addr, e.addr);
            chk($sformatf("%s.pc[%0d]", name, k), pc, e.pc);
            chk($sformatf("%s.we[%0d]", name, k), mem_we, e.we);
            chk($sformatf("%s.halted[%0d]", name, k), halted, (e.cs == CS_HALT));
            if (e.chk_alu)
                chk($sformatf("%s.alu[%0d]", name, k), alu_op, e.alu);
            if (e.drop)
                run = 1'b0;
            k++;
        end
    endtask

    // hold reset, load the image, release with run low
    task automatic boot();
        rst_n = 1'b0;
        run   = 1'b0;
        ld    = 1'b1;
        @(posedge clk); #1;
        ld    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        epc   = 4'h0;
    endtask

    task automatic clr_img();
        for (int i = 0; i < 16; i++) img[i] = 4'h0;
    endtask

    initial begin
        logic found;

        // reset mid-ALU_WB, then idle with run low
        clr_img();
        img[0] = OP_ADD; img[1] = 4'hD; img[4'hD] = 4'h3;
        boot();
        run = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); #1;
            if (cs == CS_ALU_WB) found = 1'b1;
        end
        chk("reach_alu_wb", found, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst.cs", cs, CS_IDLE);
        chk("rst.pc", pc, 4'h0);
        chk("rst.we", mem_we, 1'b0);
        chk("rst.halted", halted, 1'b0);
        chk("rst.alu", alu_op, 2'b00);
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk($sformatf("idle[%0d]", i), cs, CS_IDLE);
        end

        // LOAD E, ADD D, STORE C, HALT
        clr_img();
        img[0] = OP_LOAD;  img[1] = 4'hE;
        img[2] = OP_ADD;   img[3] = 4'hD;
        img[4] = OP_STORE; img[5] = 4'hC;
        img[6] = OP_HALT;  img[7] = 4'h0;
        img[4'hE] = 4'h5;  img[4'hD] = 4'h3;
        boot();
        run = 1'b1;
        ex(OP_LOAD, 4'hE, 1'b0);
        ex(OP_ADD, 4'hD, 1'b0);
        ex(OP_STORE, 4'hC, 1'b0);
        ex(OP_HALT, 4'h0, 1'b0);
        drain("prog");
        chk("prog.acc", acc, 4'h8);
        chk("prog.memC", mem[4'hC], 4'h8);

        // JZ taken with acc=0
        clr_img();
        img[0] = OP_JZ;   img[1] = 4'h6;
        img[6] = OP_HALT; img[7] = 4'h0;
        boot();
        run = 1'b1;
        ex(OP_JZ, 4'h6, 1'b1);
        ex(OP_HALT, 4'h0, 1'b0);
        drain("jz_t");

        // JZ not taken with acc=5
        clr_img();
        img[0] = OP_LOAD; img[1] = 4'hE;
        img[2] = OP_JZ;   img[3] = 4'h6;
        img[4] = OP_HALT; img[5] = 4'h0;
        img[4'hE] = 4'h5;
        boot();
        run = 1'b1;
        ex(OP_LOAD, 4'hE, 1'b0);
        ex(OP_JZ, 4'h6, 1'b0);
        ex(OP_HALT, 4'h0, 1'b0);
        drain("jz_nt");

        // JMP E; at E: JMP F; at F: HALT with operand from address 0
        clr_img();
        img[0] = OP_JMP; img[1] = 4'hE;
        img[4'hE] = OP_JMP; img[4'hF] = OP_HALT;
        boot();
        run = 1'b1;
        ex(OP_JMP, 4'hE, 1'b0);
        ex(OP_JMP, 4'hF, 1'b0);
        ex(OP_HALT, OP_JMP, 1'b0);
        drain("wrap");
        for (int i = 0; i < 6; i++) begin
            run = i[0];
            @(posedge clk); #1;
            chk($sformatf("halt.cs[%0d]", i), cs, CS_HALT);
            chk($sformatf("halt.flag[%0d]", i), halted, 1'b1);
        end
        rst_n = 1'b0;
        #1;
        chk("halt.rst_cs", cs, CS_IDLE);
        chk("halt.rst_flag", halted, 1'b0);

        // run dropped during FETCH_ADDR of ADD
        clr_img();
        img[0] = OP_LOAD; img[1] = 4'hE;
        img[2] = OP_ADD;  img[3] = 4'hD;
        img[4'hE] = 4'h5; img[4'hD] = 4'h3;
        boot();
        run = 1'b1;
        ex(OP_LOAD, 4'hE, 1'b0);
        ex(OP_ADD, 4'hD, 1'b0, 1'b1);
        push(CS_IDLE, 4'hD, 4'h4);
        push(CS_IDLE, 4'hD, 4'h4);
        drain("drop");
        chk("drop.acc", acc, 4'h8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
